// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : MEM-stage exception/interrupt/ERET sequencer driving the CP0
//            write port, pipeline flush/stall and PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_bd_i,
    input  logic [5:0]  exc_vec_i,
    input  logic        eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_waddr_i,
    input  logic [31:0] pipe_wdata_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_wdata_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        redirect_o,
    output logic [31:0] new_pc_o,
    output logic [4:0]  exc_code_o,
    output logic        exc_bd_o,
    output logic        cause_upd_o
);

    localparam logic [4:0] c_addr_status = 5'd12;
    localparam logic [4:0] c_addr_epc    = 5'd14;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_EPC    = 2'd1,
        WR_STATUS = 2'd2,
        ERET_WR   = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_epc_val;
    logic        r_skip_epc;
    logic [4:0]  r_exc_code;
    logic        r_exc_bd;

    logic        w_int_pend;
    logic        w_take;
    logic        w_eret;
    logic [4:0]  w_code;
    logic        w_unused_cause;

    assign w_int_pend = mem_valid_i && (|(cause_i[15:8] & status_i[15:8]))
                        && status_i[0] && !status_i[1];
    assign w_take     = mem_valid_i && (w_int_pend || (|exc_vec_i));
    assign w_eret     = mem_valid_i && eret_i;
    assign w_unused_cause = ^{cause_i[31:16], cause_i[7:0]};

    // Priority: Int > AdEL > RI > Ov > Sys > Bp > AdES
    always_comb begin
        w_code = 5'd0;
        if (w_int_pend)        w_code = 5'd0;
        else if (exc_vec_i[0]) w_code = 5'd4;
        else if (exc_vec_i[1]) w_code = 5'd10;
        else if (exc_vec_i[2]) w_code = 5'd12;
        else if (exc_vec_i[3]) w_code = 5'd8;
        else if (exc_vec_i[4]) w_code = 5'd9;
        else if (exc_vec_i[5]) w_code = 5'd5;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_epc_val  <= 32'd0;
            r_skip_epc <= 1'b0;
            r_exc_code <= 5'd0;
            r_exc_bd   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_exc_code <= w_code;
                        r_exc_bd   <= mem_bd_i;
                        r_epc_val  <= mem_bd_i ? (mem_pc_i - 32'd4) : mem_pc_i;
                        // Nested exception under EXL keeps the original EPC
                        r_skip_epc <= status_i[1];
                        r_state    <= WR_EPC;
                    end else if (w_eret) begin
                        r_state <= ERET_WR;
                    end
                end
                WR_EPC:    r_state <= WR_STATUS;
                WR_STATUS: r_state <= IDLE;
                ERET_WR:   r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cp0_we_o    = pipe_we_i;
        cp0_waddr_o = pipe_waddr_i;
        cp0_wdata_o = pipe_wdata_i;
        flush_o     = 1'b0;
        stall_o     = 1'b0;
        redirect_o  = 1'b0;
        new_pc_o    = 32'd0;
        cause_upd_o = 1'b0;
        case (r_state)
            WR_EPC: begin
                flush_o     = 1'b1;
                stall_o     = 1'b1;
                cause_upd_o = 1'b1;
                cp0_we_o    = !r_skip_epc;
                cp0_waddr_o = c_addr_epc;
                cp0_wdata_o = r_epc_val;
            end
            WR_STATUS: begin
                flush_o     = 1'b1;
                cp0_we_o    = 1'b1;
                cp0_waddr_o = c_addr_status;
                cp0_wdata_o = status_i | 32'h2;
                redirect_o  = 1'b1;
                new_pc_o    = EXC_VECTOR;
            end
            ERET_WR: begin
                flush_o     = 1'b1;
                cp0_we_o    = 1'b1;
                cp0_waddr_o = c_addr_status;
                cp0_wdata_o = status_i & ~32'h2;
                redirect_o  = 1'b1;
                new_pc_o    = epc_i;
            end
            default: ;
        endcase
    end

    assign exc_code_o = r_exc_code;
    assign exc_bd_o   = r_exc_bd;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Table-driven, random-vs-model and hand-sequence bench for exc_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    localparam logic [31:0] c_vector = 32'hBFC00380;
    localparam int c_none = 0;
    localparam int c_exc  = 1;
    localparam int c_eret = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_bd_i;
    logic [5:0]  exc_vec_i;
    logic        eret_i;
    logic [31:0] status_i, cause_i, epc_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_wdata_o;
    logic        flush_o, stall_o, redirect_o;
    logic [31:0] new_pc_o;
    logic [4:0]  exc_code_o;
    logic        exc_bd_o, cause_upd_o;

    exc_ctrl #(.EXC_VECTOR(c_vector)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_bd_i(mem_bd_i),
        .exc_vec_i(exc_vec_i), .eret_i(eret_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
        .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
        .flush_o(flush_o), .stall_o(stall_o), .redirect_o(redirect_o),
        .new_pc_o(new_pc_o), .exc_code_o(exc_code_o), .exc_bd_o(exc_bd_o),
        .cause_upd_o(cause_upd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic [5:0]  vec;
        logic        eret;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        int          kind;
        logic [4:0]  code;
        logic        ebd;
        logic        epc_we;
        logic [31:0] epc_val;
        logic [31:0] st_val;
        logic [31:0] npc;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] held_code = 5'd0;
    logic       held_bd = 1'b0;
    vec_t       table_v[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic bd,
                                input logic [5:0] vec, input logic eret,
                                input logic [31:0] status, input logic [31:0] cause,
                                input logic [31:0] epc, input int kind, input logic [4:0] code,
                                input logic ebd, input logic we, input logic [31:0] epcv,
                                input logic [31:0] st, input logic [31:0] npc);
        vec_t v;
        v.valid = valid; v.pc = pc; v.bd = bd; v.vec = vec; v.eret = eret;
        v.status = status; v.cause = cause; v.epc = epc;
        v.kind = kind; v.code = code; v.ebd = ebd; v.epc_we = we;
        v.epc_val = epcv; v.st_val = st; v.npc = npc;
        return v;
    endfunction

    // Reference model: priority list scanned in order, arithmetic EPC.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   codes[7] = '{0, 4, 10, 12, 8, 9, 5};
        logic hit[7];
        logic irq;
        irq = v.valid && ((v.cause[15:8] & v.status[15:8]) != 8'd0)
              && v.status[0] && !v.status[1];
        hit[0] = irq;
        for (int i = 0; i < 6; i++) hit[i+1] = v.vec[i];
        r.kind = c_none; r.code = 5'd0; r.ebd = 1'b0; r.epc_we = 1'b0;
        r.epc_val = 32'd0; r.st_val = 32'd0; r.npc = 32'd0;
        if (v.valid) begin
            for (int i = 0; i < 7; i++) begin
                if (hit[i] && r.kind == c_none) begin
                    r.kind = c_exc;
                    r.code = 5'(codes[i]);
                end
            end
            if (r.kind == c_exc) begin
                r.ebd     = v.bd;
                r.epc_we  = !v.status[1];
                r.epc_val = v.bd ? v.pc - 32'd4 : v.pc;
                r.st_val  = v.status | 32'h2;
                r.npc     = c_vector;
            end else if (v.eret) begin
                r.kind   = c_eret;
                r.st_val = v.status & ~32'h2;
                r.npc    = v.epc;
            end
        end
        return r;
    endfunction

    // Entered mid-cycle while the DUT is in IDLE; returns mid-cycle in IDLE.
    task automatic run_case(input vec_t v, input string nm);
        logic [4:0]  pa;
        logic [31:0] pd;
        pa = 5'($urandom_range(0, 11));
        pd = $urandom;
        mem_valid_i = v.valid; mem_pc_i = v.pc; mem_bd_i = v.bd;
        exc_vec_i = v.vec; eret_i = v.eret;
        status_i = v.status; cause_i = v.cause; epc_i = v.epc;
        pipe_we_i = 1'b1; pipe_waddr_i = pa; pipe_wdata_i = pd;
        #1;
        chk({nm, " T pass_we"}, 32'(cp0_we_o), 32'd1);
        chk({nm, " T pass_addr"}, 32'(cp0_waddr_o), 32'(pa));
        chk({nm, " T pass_data"}, cp0_wdata_o, pd);
        chk({nm, " T ctrl"}, {flush_o, stall_o, redirect_o, cause_upd_o}, 32'd0);
        @(posedge clk); #1;
        mem_valid_i = 1'b0; exc_vec_i = 6'd0; eret_i = 1'b0;
        @(negedge clk);
        if (v.kind == c_exc) begin
            held_code = v.code; held_bd = v.ebd;
            chk({nm, " T1 ctrl"}, {flush_o, stall_o, redirect_o, cause_upd_o}, 32'b1101);
            chk({nm, " T1 epc_we"}, 32'(cp0_we_o), 32'(v.epc_we));
            chk({nm, " T1 epc_addr"}, 32'(cp0_waddr_o), 32'd14);
            chk({nm, " T1 epc_data"}, cp0_wdata_o, v.epc_val);
            chk({nm, " T1 code"}, 32'(exc_code_o), 32'(v.code));
            chk({nm, " T1 bd"}, 32'(exc_bd_o), 32'(v.ebd));
            @(negedge clk);
            chk({nm, " T2 ctrl"}, {flush_o, stall_o, redirect_o, cause_upd_o}, 32'b1010);
            chk({nm, " T2 st_we"}, {cp0_we_o, cp0_waddr_o}, {26'd0, 1'b1, 5'd12});
            chk({nm, " T2 st_data"}, cp0_wdata_o, v.st_val);
            chk({nm, " T2 new_pc"}, new_pc_o, v.npc);
            @(negedge clk);
        end else if (v.kind == c_eret) begin
            chk({nm, " E1 ctrl"}, {flush_o, stall_o, redirect_o, cause_upd_o}, 32'b1010);
            chk({nm, " E1 st_we"}, {cp0_we_o, cp0_waddr_o}, {26'd0, 1'b1, 5'd12});
            chk({nm, " E1 st_data"}, cp0_wdata_o, v.st_val);
            chk({nm, " E1 new_pc"}, new_pc_o, v.npc);
            @(negedge clk);
        end
        chk({nm, " idle ctrl"}, {flush_o, stall_o, redirect_o, cause_upd_o}, 32'd0);
        chk({nm, " idle pass"}, {cp0_we_o, cp0_waddr_o}, {26'd0, 1'b1, pa});
        chk({nm, " held code"}, {exc_bd_o, exc_code_o}, {held_bd, held_code});
        pipe_we_i = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        mem_valid_i = 0; mem_pc_i = 0; mem_bd_i = 0; exc_vec_i = 0; eret_i = 0;
        status_i = 0; cause_i = 0; epc_i = 0;
        pipe_we_i = 0; pipe_waddr_i = 0; pipe_wdata_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd9; pipe_wdata_i = 32'h12345678;
        @(negedge clk);
        chk("reset ctrl", {flush_o, stall_o, redirect_o, cause_upd_o}, 32'd0);
        chk("reset code", {exc_bd_o, exc_code_o}, 32'd0);
        chk("reset pass", cp0_wdata_o, 32'h12345678);
        chk("reset new_pc", new_pc_o, 32'd0);
        pipe_we_i = 1'b0;

        table_v.push_back(mk(1, 32'h80000100, 0, 6'b000100, 0, 32'h10000001, 0, 0,
                             c_exc, 12, 0, 1, 32'h80000100, 32'h10000003, c_vector));
        table_v.push_back(mk(1, 32'h80000204, 1, 6'b001000, 0, 32'h10000001, 0, 0,
                             c_exc, 8, 1, 1, 32'h80000200, 32'h10000003, c_vector));
        table_v.push_back(mk(1, 32'h80000400, 0, 6'b000010, 0, 32'h10000401, 32'h400, 0,
                             c_exc, 0, 0, 1, 32'h80000400, 32'h10000403, c_vector));
        table_v.push_back(mk(1, 32'h80000500, 0, 6'b000010, 0, 32'h10000403, 32'h400, 0,
                             c_exc, 10, 0, 0, 32'h80000500, 32'h10000403, c_vector));
        table_v.push_back(mk(1, 32'h80000600, 0, 6'b000000, 0, 32'h10000403, 32'h400, 0,
                             c_none, 0, 0, 0, 0, 0, 0));
        table_v.push_back(mk(1, 32'h80000700, 0, 6'b000000, 1, 32'h10000003, 0, 32'h80000300,
                             c_eret, 0, 0, 0, 0, 32'h10000001, 32'h80000300));
        table_v.push_back(mk(1, 32'h80000800, 0, 6'b000001, 1, 32'h10000003, 0, 32'h80000300,
                             c_exc, 4, 0, 0, 32'h80000800, 32'h10000003, c_vector));
        table_v.push_back(mk(1, 32'h00000000, 1, 6'b010000, 0, 32'h00000001, 0, 0,
                             c_exc, 9, 1, 1, 32'hFFFFFFFC, 32'h00000003, c_vector));
        table_v.push_back(mk(1, 32'h80000900, 0, 6'b100000, 0, 32'h0, 0, 0,
                             c_exc, 5, 0, 1, 32'h80000900, 32'h2, c_vector));
        table_v.push_back(mk(1, 32'h80000A00, 0, 6'b110000, 0, 32'h0, 0, 0,
                             c_exc, 9, 0, 1, 32'h80000A00, 32'h2, c_vector));
        table_v.push_back(mk(0, 32'h80000B00, 0, 6'b000100, 1, 32'h10000401, 32'h400, 0,
                             c_none, 0, 0, 0, 0, 0, 0));
        table_v.push_back(mk(1, 32'h80000C00, 0, 6'b000000, 0, 32'h10000400, 32'h400, 0,
                             c_none, 0, 0, 0, 0, 0, 0));
        foreach (table_v[i]) run_case(table_v[i], $sformatf("vec%0d", i));

        for (int n = 0; n < 200; n++) begin
            v.valid  = ($urandom_range(0, 3) != 0);
            v.pc     = {$urandom} & ~32'h3;
            v.bd     = 1'($urandom);
            v.vec    = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            v.eret   = v.valid && ($urandom_range(0, 3) == 0);
            v.status = $urandom;
            v.cause  = $urandom_range(0, 1) ? ($urandom & 32'h0000FF00) : 32'd0;
            v.epc    = $urandom;
            run_case(model(v), $sformatf("rnd%0d", n));
        end

        // Reset while in WR_EPC abandons the sequence
        mem_valid_i = 1; mem_pc_i = 32'h80000100; mem_bd_i = 0; exc_vec_i = 6'b000100;
        status_i = 32'h10000001; cause_i = 0;
        @(posedge clk); #1;
        mem_valid_i = 0; exc_vec_i = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid in WR_EPC", {flush_o, stall_o, cause_upd_o}, 32'b111);
        @(posedge clk); #1;
        rst = 1'b0;
        held_code = 5'd0; held_bd = 1'b0;
        @(negedge clk);
        chk("rst_mid ctrl", {flush_o, stall_o, redirect_o, cause_upd_o}, 32'd0);
        chk("rst_mid cp0_we", 32'(cp0_we_o), 32'd0);
        chk("rst_mid code", {exc_bd_o, exc_code_o}, {held_bd, held_code});
        @(negedge clk);
        chk("rst_mid later", {cp0_we_o, redirect_o, flush_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
